// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register.
// Provides stall/reset encodings, NOP op/sel codes and the packed ID/EX
// payload layout so the producing and consuming stages agree on field offsets.
package pipe_stage_reg_pkg;

    localparam logic STOP          = 1'b1;
    localparam logic NOSTOP        = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [4:0] EXE_NOP_OP  = 5'b00000;
    localparam logic [2:0] EXE_RES_NOP = 3'b000;

    // ID/EX payload, MSB first
    typedef struct packed {
        logic [4:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
    } idex_payload_t;

    localparam int unsigned IDEX_W = $bits(idex_payload_t);

    localparam idex_payload_t NOP_IDEX_PAYLOAD = '{
        aluop:  EXE_NOP_OP,
        alusel: EXE_RES_NOP,
        reg1:   32'h0,
        reg2:   32'h0,
        wd:     5'h0,
        wreg:   WRITE_DISABLE
    };

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data channel between pipeline stages.
//   valid : producer has a payload
//   ready : consumer can take it
//   data  : opaque payload
// master = producer side, slave = consumer side.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 78
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : synchronous clear
//   i_inc    : increment request
//   o_cnt    : current count
module pipe_stage_reg_sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register.
// MODE 0: global stall-vector control with bubble insertion and flush.
// MODE 1: elastic valid/ready with a 2-entry (main + skid) buffer.
//   clk, rst     : clock, synchronous active-high reset
//   i_stall      : global stall vector (MODE 0 only), 1 = STOP
//   i_flush      : squash all held contents
//   i_up         : upstream channel (valid/data in, ready out)
//   o_dn         : downstream channel (valid/data out, ready in; ready MODE 1 only)
//   o_bubble_cnt : saturating count of bubble cycles
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W      = IDEX_W,
    parameter int unsigned       STALL_W     = 6,
    parameter int unsigned       STAGE       = 2,
    parameter logic [DATA_W-1:0] NOP_PAYLOAD = DATA_W'(NOP_IDEX_PAYLOAD),
    parameter int unsigned       MODE        = 0,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] i_stall,
    input  logic               i_flush,
    pipe_stage_reg_if.slave    i_up,
    pipe_stage_reg_if.master   o_dn,
    output logic [CNT_W-1:0]   o_bubble_cnt
);

    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              w_inc;
    logic [CNT_W-1:0]  w_bubble_cnt;
    logic              w_unused;

    // Stall bits outside this stage's pair and the mode-specific unused inputs
    assign w_unused = ^{i_stall, o_dn.ready};

    generate
        if (MODE == 0) begin : g_stall
            // Stage stalled but next stage moving: emit a bubble downstream
            always_ff @(posedge clk) begin
                if (rst == RST_ENABLE) begin
                    r_data  <= NOP_PAYLOAD;
                    r_valid <= 1'b0;
                end else if (i_flush) begin
                    r_data  <= NOP_PAYLOAD;
                    r_valid <= 1'b0;
                end else if (i_stall[STAGE] == NOSTOP) begin
                    r_data  <= i_up.data;
                    r_valid <= i_up.valid;
                end else if (i_stall[STAGE+1] == NOSTOP) begin
                    r_data  <= NOP_PAYLOAD;
                    r_valid <= 1'b0;
                end
            end

            assign i_up.ready = (i_stall[STAGE] == NOSTOP);
            assign w_inc      = i_flush |
                                ((i_stall[STAGE] == STOP) && (i_stall[STAGE+1] == NOSTOP));
        end else begin : g_elastic
            localparam logic [1:0] ST_EMPTY = 2'd0;
            localparam logic [1:0] ST_ONE   = 2'd1;
            localparam logic [1:0] ST_FULL  = 2'd2;

            logic [1:0]        r_state;
            logic [1:0]        w_state_nxt;
            logic [DATA_W-1:0] r_skid;
            logic [DATA_W-1:0] w_skid_nxt;
            logic [DATA_W-1:0] w_main_nxt;
            logic              r_in_ready;

            // State and buffer registers; valid/ready decoded from next state
            always_ff @(posedge clk) begin
                if (rst == RST_ENABLE) begin
                    r_state    <= ST_EMPTY;
                    r_data     <= NOP_PAYLOAD;
                    r_skid     <= NOP_PAYLOAD;
                    r_valid    <= 1'b0;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_data     <= w_main_nxt;
                    r_skid     <= w_skid_nxt;
                    r_valid    <= (w_state_nxt != ST_EMPTY);
                    r_in_ready <= (w_state_nxt != ST_FULL);
                end
            end

            // Next-state and buffer steering
            always_comb begin
                w_state_nxt = r_state;
                w_main_nxt  = r_data;
                w_skid_nxt  = r_skid;
                if (i_flush) begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = NOP_PAYLOAD;
                    w_skid_nxt  = NOP_PAYLOAD;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (i_up.valid) begin
                                w_main_nxt  = i_up.data;
                                w_state_nxt = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (o_dn.ready && i_up.valid) begin
                                w_main_nxt = i_up.data;
                            end else if (o_dn.ready) begin
                                w_state_nxt = ST_EMPTY;
                            end else if (i_up.valid) begin
                                w_skid_nxt  = i_up.data;
                                w_state_nxt = ST_FULL;
                            end
                        end
                        ST_FULL: begin
                            if (o_dn.ready) begin
                                w_main_nxt  = r_skid;
                                w_state_nxt = ST_ONE;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_EMPTY;
                        end
                    endcase
                end
            end

            assign i_up.ready = r_in_ready;
            assign w_inc      = i_flush | (o_dn.ready & ~r_valid);
        end
    endgenerate

    pipe_stage_reg_sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_inc (w_inc),
        .o_cnt (w_bubble_cnt)
    );

    assign o_dn.data    = r_data;
    assign o_dn.valid   = r_valid;
    assign o_bubble_cnt = w_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: stall-vector mode, elastic mode
// and a narrow saturating counter instance.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 78;
    localparam logic [DW-1:0] NOP = 78'h3_0000_0000_0000_00A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [5:0]  stall0, stall1, stall2;
    logic        flush0, flush1, flush2;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    pipe_stage_reg_if #(.DATA_W(DW)) up0 ();
    pipe_stage_reg_if #(.DATA_W(DW)) dn0 ();
    pipe_stage_reg_if #(.DATA_W(DW)) up1 ();
    pipe_stage_reg_if #(.DATA_W(DW)) dn1 ();
    pipe_stage_reg_if #(.DATA_W(DW)) up2 ();
    pipe_stage_reg_if #(.DATA_W(DW)) dn2 ();

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(6), .STAGE(2), .NOP_PAYLOAD(NOP), .MODE(0), .CNT_W(16))
    u_m0 (.clk(clk), .rst(rst), .i_stall(stall0), .i_flush(flush0), .i_up(up0), .o_dn(dn0), .o_bubble_cnt(cnt0));

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(6), .STAGE(2), .NOP_PAYLOAD(NOP), .MODE(1), .CNT_W(16))
    u_m1 (.clk(clk), .rst(rst), .i_stall(stall1), .i_flush(flush1), .i_up(up1), .o_dn(dn1), .o_bubble_cnt(cnt1));

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(6), .STAGE(2), .NOP_PAYLOAD(NOP), .MODE(0), .CNT_W(2))
    u_sat (.clk(clk), .rst(rst), .i_stall(stall2), .i_flush(flush2), .i_up(up2), .o_dn(dn2), .o_bubble_cnt(cnt2));

    // Reference state: MODE 0 register contents, MODE 1 in-flight FIFO
    logic [DW-1:0] e0_data;
    logic          e0_valid;
    int            e0_cnt;
    logic [DW-1:0] q1[$];
    logic [DW-1:0] got[$];
    int            e1_cnt;
    logic          e1_nop;

    // Upstream must hold a beat that was presented but not accepted
    logic          p_hold = 1'b0;
    logic [DW-1:0] p_data;
    always @(posedge clk) begin
        if (p_hold)
            assert (up1.valid === 1'b1 && up1.data === p_data)
            else $error("upstream beat withdrawn or changed while not accepted");
        p_hold <= !rst && !flush1 && up1.valid && !up1.ready;
        p_data <= up1.data;
    end

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic model_reset();
        e0_data = NOP; e0_valid = 1'b0; e0_cnt = 0;
        q1.delete(); e1_cnt = 0; e1_nop = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush0 = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
        stall0 = 6'($urandom()); stall1 = 6'($urandom()); stall2 = 6'b0;
        up0.valid = 1'b0; up0.data = rnd_data(); dn0.ready = 1'b1;
        up1.valid = 1'b0; up1.data = rnd_data(); dn1.ready = 1'b0;
        up2.valid = 1'b0; up2.data = rnd_data(); dn2.ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One MODE 0 cycle: drive, check combinational ready, clock, check state
    task automatic m0_cycle(input logic [5:0] st, input logic fl, input logic iv, input logic [DW-1:0] d);
        stall0 = st; flush0 = fl; up0.valid = iv; up0.data = d; dn0.ready = 1'($urandom());
        #1;
        checks++;
        if (up0.ready !== ~st[2]) begin errors++; $display("FAIL m0_in_ready got=%b exp=%b", up0.ready, ~st[2]); end
        if (fl) begin
            e0_data = NOP; e0_valid = 1'b0; e0_cnt++;
        end else if (!st[2]) begin
            e0_data = d; e0_valid = iv;
        end else if (!st[3]) begin
            e0_data = NOP; e0_valid = 1'b0; e0_cnt++;
        end
        @(posedge clk); #1;
        checks += 3;
        if (dn0.data !== e0_data) begin errors++; $display("FAIL m0_out_data got=%h exp=%h", dn0.data, e0_data); end
        if (dn0.valid !== e0_valid) begin errors++; $display("FAIL m0_out_valid got=%b exp=%b", dn0.valid, e0_valid); end
        if (cnt0 !== 16'(e0_cnt)) begin errors++; $display("FAIL m0_bubble_cnt got=%0d exp=%0d", cnt0, e0_cnt); end
    endtask

    // One MODE 1 cycle: FIFO-occupancy model of the elastic buffer
    task automatic m1_cycle(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        logic ir_m, ov_m;
        logic [DW-1:0] tmp;
        up1.valid = iv; up1.data = d; dn1.ready = ordy; flush1 = fl; stall1 = 6'($urandom());
        if (dn1.valid && ordy && !fl) got.push_back(dn1.data);
        ir_m = (q1.size() < 2);
        ov_m = (q1.size() > 0);
        if (fl) begin
            q1.delete(); e1_cnt++; e1_nop = 1'b1;
        end else begin
            if (ordy && !ov_m) e1_cnt++;
            if (ov_m && ordy) tmp = q1.pop_front();
            if (iv && ir_m) begin q1.push_back(d); e1_nop = 1'b0; end
        end
        @(posedge clk); #1;
        checks += 3;
        if (dn1.valid !== (q1.size() > 0)) begin errors++; $display("FAIL m1_out_valid got=%b exp=%b", dn1.valid, q1.size() > 0); end
        if (up1.ready !== (q1.size() < 2)) begin errors++; $display("FAIL m1_in_ready got=%b exp=%b", up1.ready, q1.size() < 2); end
        if (cnt1 !== 16'(e1_cnt)) begin errors++; $display("FAIL m1_bubble_cnt got=%0d exp=%0d", cnt1, e1_cnt); end
        if (q1.size() > 0) begin
            checks++;
            if (dn1.data !== q1[0]) begin errors++; $display("FAIL m1_out_data got=%h exp=%h", dn1.data, q1[0]); end
        end else if (e1_nop) begin
            checks++;
            if (dn1.data !== NOP) begin errors++; $display("FAIL m1_out_nop got=%h exp=%h", dn1.data, NOP); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall0 = 6'b000100; flush0 = 1'b1; up0.valid = 1'b1; up0.data = rnd_data();
        flush1 = 1'b0; up1.valid = 1'b1; up1.data = rnd_data(); dn1.ready = 1'b1;
        flush2 = 1'b0; stall2 = 6'b0; up2.valid = 1'b0; up2.data = rnd_data(); dn2.ready = 1'b1;
        @(posedge clk); #1;
        checks += 8;
        if (dn0.data !== NOP)    begin errors++; $display("FAIL rst_m0_data got=%h exp=%h", dn0.data, NOP); end
        if (dn0.valid !== 1'b0)  begin errors++; $display("FAIL rst_m0_valid got=%b exp=0", dn0.valid); end
        if (cnt0 !== 16'd0)      begin errors++; $display("FAIL rst_m0_cnt got=%0d exp=0", cnt0); end
        if (up0.ready !== 1'b0)  begin errors++; $display("FAIL rst_m0_ready got=%b exp=0", up0.ready); end
        if (dn1.data !== NOP)    begin errors++; $display("FAIL rst_m1_data got=%h exp=%h", dn1.data, NOP); end
        if (dn1.valid !== 1'b0)  begin errors++; $display("FAIL rst_m1_valid got=%b exp=0", dn1.valid); end
        if (cnt1 !== 16'd0)      begin errors++; $display("FAIL rst_m1_cnt got=%0d exp=0", cnt1); end
        if (up1.ready !== 1'b1)  begin errors++; $display("FAIL rst_m1_ready got=%b exp=1", up1.ready); end
        do_reset();
    endtask

    task automatic test_m0_bubble();
        do_reset();
        m0_cycle(6'b000100, 1'b0, 1'b1, DW'(12'hABC));
        checks++;
        if (up0.ready !== 1'b0) begin errors++; $display("FAIL m0_bubble_ready got=%b exp=0", up0.ready); end
    endtask

    task automatic test_m0_hold();
        do_reset();
        m0_cycle(6'b000000, 1'b0, 1'b1, DW'(12'h123));
        for (int i = 0; i < 3; i++) m0_cycle(6'b001100, 1'b0, 1'($urandom()), rnd_data());
    endtask

    task automatic test_m0_flush();
        logic [DW-1:0] d;
        do_reset();
        m0_cycle(6'b000000, 1'b0, 1'b1, rnd_data());
        m0_cycle(6'b000000, 1'b1, 1'b1, DW'(8'h55));
        // reset wins over flush: counter must clear
        rst = 1'b1; flush0 = 1'b1; stall0 = 6'b0; up0.valid = 1'b1; d = DW'(8'h55); up0.data = d;
        @(posedge clk); #1;
        checks += 3;
        if (cnt0 !== 16'd0)     begin errors++; $display("FAIL m0_rst_flush_cnt got=%0d exp=0", cnt0); end
        if (dn0.data !== NOP)   begin errors++; $display("FAIL m0_rst_flush_data got=%h exp=%h", dn0.data, NOP); end
        if (dn0.valid !== 1'b0) begin errors++; $display("FAIL m0_rst_flush_valid got=%b exp=0", dn0.valid); end
        rst = 1'b0; flush0 = 1'b0;
        model_reset();
    endtask

    task automatic test_m0_random();
        do_reset();
        for (int i = 0; i < 200; i++)
            m0_cycle(6'($urandom()), ($urandom_range(0, 15) == 0), 1'($urandom()), rnd_data());
    endtask

    task automatic test_m1_back_to_back();
        logic [DW-1:0] exp_ord [3];
        exp_ord[0] = DW'(1); exp_ord[1] = DW'(2); exp_ord[2] = DW'(3);
        do_reset();
        got.delete();
        m1_cycle(1'b1, DW'(1), 1'b1, 1'b0);
        m1_cycle(1'b1, DW'(2), 1'b0, 1'b0);
        checks++;
        if (up1.ready !== 1'b0) begin errors++; $display("FAIL m1_b2b_ready_drop got=%b exp=0", up1.ready); end
        m1_cycle(1'b1, DW'(3), 1'b0, 1'b0);
        m1_cycle(1'b1, DW'(3), 1'b0, 1'b0);
        m1_cycle(1'b1, DW'(3), 1'b1, 1'b0);
        m1_cycle(1'b1, DW'(3), 1'b1, 1'b0);
        m1_cycle(1'b0, rnd_data(), 1'b1, 1'b0);
        m1_cycle(1'b0, rnd_data(), 1'b1, 1'b0);
        checks++;
        if (got.size() != 3) begin
            errors++; $display("FAIL m1_b2b_count got=%0d exp=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== exp_ord[i]) begin errors++; $display("FAIL m1_b2b_order idx=%0d got=%h exp=%h", i, got[i], exp_ord[i]); end
            end
        end
    endtask

    task automatic test_m1_flush_full();
        do_reset();
        m1_cycle(1'b1, DW'(16'hA0A0), 1'b0, 1'b0);
        m1_cycle(1'b1, DW'(16'hB0B0), 1'b0, 1'b0);
        m1_cycle(1'b1, DW'(16'hC0C0), 1'b0, 1'b1);
        m1_cycle(1'b0, rnd_data(), 1'b1, 1'b0);
        m1_cycle(1'b1, DW'(16'hD0D0), 1'b0, 1'b0);
        m1_cycle(1'b0, rnd_data(), 1'b1, 1'b0);
        up1.valid = 1'b0; flush1 = 1'b0;
    endtask

    task automatic test_m1_random();
        logic hold, iv, fl, ir_before;
        logic [DW-1:0] hd, d;
        do_reset();
        hold = 1'b0; hd = '0;
        for (int i = 0; i < 300; i++) begin
            if (hold) begin iv = 1'b1; d = hd; end
            else begin iv = ($urandom_range(0, 3) != 0); d = rnd_data(); end
            fl = ($urandom_range(0, 31) == 0);
            ir_before = (q1.size() < 2);
            m1_cycle(iv, d, ($urandom_range(0, 2) != 0), fl);
            hold = iv && !ir_before && !fl;
            hd = d;
        end
        m1_cycle(1'b0, rnd_data(), 1'b1, 1'b0);
        m1_cycle(1'b0, rnd_data(), 1'b1, 1'b0);
        up1.valid = 1'b0;
    endtask

    task automatic test_saturation();
        int exp;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            stall2 = 6'b000100; flush2 = 1'b0; up2.valid = 1'($urandom()); up2.data = rnd_data();
            @(posedge clk); #1;
            exp = (k > 3) ? 3 : k;
            checks++;
            if (cnt2 !== 2'(exp)) begin errors++; $display("FAIL sat_cnt cycle=%0d got=%0d exp=%0d", k, cnt2, exp); end
        end
        stall2 = 6'b0;
    endtask

    initial begin
        test_reset();
        test_m0_bubble();
        test_m0_hold();
        test_m0_flush();
        test_m0_random();
        test_m1_back_to_back();
        test_m1_flush_full();
        test_m1_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
